lift_car_controller: RTL
========================

# lift_car_controller

Per-car motion and door controller that sits on the far side of the hall-call dispatcher. It accepts floor assignments from the dispatcher and cabin-button calls, queues them in a pending-floor bitmap, and serves them in SCAN order (keep direction while calls remain ahead). It reports `curr_floor` and `dest_floor` back to the dispatcher. One instance exists per car.

## Interface
Parameters:
- `FLOORS`, 8: number of served floors, legal range 2..8; floors are 0..FLOORS-1.
- `TRAVEL_CYCLES`, 4: clock cycles to move one floor, at least 1.
- `DOOR_CYCLES`, 8: clock cycles the door stays open per stop, at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `assign_valid`  in  1  dispatcher offers an assignment.
- `assign_floor`  in  3  assigned floor.
- `assign_ready`  out  1  car can accept an assignment; a transfer occurs when `assign_valid & assign_ready` at a clock edge.
- `cab_call`  in  8  cabin buttons, one bit per floor, level-sampled every cycle.
- `curr_floor`  out  3  last floor reached or passed.
- `dest_floor`  out  3  next stop; equals `curr_floor` when the car is not moving.
- `moving`  out  1  high in the MOVE state.
- `dir_up`  out  1  travel direction or direction preference; 1 = up.
- `door_open`  out  1  high in the DOOR state.
- `pending`  out  8  outstanding-call bitmap.

## Operation
- Reset values: `curr_floor` = 0, `pending` = 0, state IDLE, `dir_up` = 1, `door_open` = 0, `moving` = 0, `assign_ready` = 0. `assign_ready` rises on the first cycle after reset is released and then stays at 1.
- Request capture, every cycle:
  - A handshaked `assign_floor` sets `pending[assign_floor]`.
  - Each high `cab_call[i]` sets `pending[i]`.
  - Floors at or above FLOORS are acknowledged and dropped. `cab_call` bits at FLOORS and above are ignored.
  - An assignment and a cab call to the same floor in the same cycle set one bit.
- Same-floor requests:
  - A request for `curr_floor` in IDLE goes to DOOR; no bit is set.
  - In DOOR, behaviour depends on `DOOR_REOPEN_EN` (see Configuration).
  - In MOVE, a request for `curr_floor` sets the bit. That call is served after the car reverses.
- Direction selection, on leaving IDLE or DOOR with `pending` nonzero:
  - Keep `dir_up` if any pending floor lies in that direction.
  - Otherwise reverse.
- FSM:
  - IDLE → MOVE when `pending` is nonzero. The travel counter loads TRAVEL_CYCLES-1.
  - MOVE: the counter decrements. At 0, `curr_floor` steps ±1.
    - If the new floor's bit is set (including a bit set in that same cycle), clear it and go to DOOR.
    - Otherwise reload the counter and continue.
  - DOOR: the door counter loads DOOR_CYCLES-1 on entry and decrements. At 0:
    - go to MOVE, with direction re-selected, if `pending` is nonzero;
    - otherwise go to IDLE.
- `dest_floor` is combinational from registered state:
  - MOVE, up: the lowest pending floor above `curr_floor`.
  - MOVE, down: the highest pending floor below `curr_floor`.
  - Otherwise: `curr_floor`.
- Bounds: `curr_floor` never leaves 0..FLOORS-1. Selection guarantees a target exists in the travel direction, so no wrap-around can occur.

## Timing
- Request to first floor step: IDLE to MOVE takes 1 cycle; the first step lands TRAVEL_CYCLES cycles after entering MOVE.
- Per-floor travel: exactly TRAVEL_CYCLES cycles.
- Door: `door_open` is high for exactly DOOR_CYCLES cycles per stop, unless extended by a reopen.
- Outputs are registered, except `dest_floor`, which is combinational with no input-to-output path.
- Reset mid-operation: all state returns to reset values on the next edge; in-flight `pending` bits are discarded.

## Configuration
- `LIFT_DOOR_REOPEN_EN` defined: a request for `curr_floor` in DOOR reloads the door counter to DOOR_CYCLES-1, extending the open time.
- Undefined: such a request is acknowledged and discarded, and the door closes on its original schedule.

## Test plan
- Reset, then assignment to floor 3 at cycle 2, with TRAVEL_CYCLES = 4 and DOOR_CYCLES = 8 -> `curr_floor` reaches 3 after 12 MOVE cycles; `door_open` is high for 8 cycles; IDLE follows with `pending` = 0 and `dest_floor` = 3.
- Car at floor 2 moving up to 6; cab call at floor 4 -> `dest_floor` changes to 4, the car stops at 4 and then continues to 6.
- Car moving up from 0 to 5; assignment to floor 1 when `curr_floor` = 2 -> the car serves 5 first, then reverses with `dir_up` = 0 and stops at 1.
- Door open at floor 4; assignment to floor 4 arrives 5 cycles into the stop -> with `LIFT_DOOR_REOPEN_EN`, the door is open for 13 cycles in total; without it, 8 cycles and `pending[4]` stays 0.
- FLOORS = 6; assignment to floor 7 -> handshake completes and `pending` is unchanged.
- Reset asserted while in MOVE with `pending` = 8'h30 -> on the next edge `curr_floor` = 0, `pending` = 0, `moving` = 0, `assign_ready` = 0.

Source files
------------

// File: rtl/lift_car_controller.sv
// Per-car SCAN controller: queues assignments and cab calls in a floor bitmap and moves the car between stops.
// Latency: IDLE->MOVE 1 cycle, TRAVEL_CYCLES per floor, DOOR_CYCLES open per stop; dest_floor is combinational from state.
// Backpressure: assign_ready is low only during reset and the first cycle after. Optional LIFT_DOOR_REOPEN_EN extends the door on same-floor calls.
module lift_car_controller #(
    parameter int FLOORS        = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       assign_valid,
    input  logic [2:0] assign_floor,
    output logic       assign_ready,
    input  logic [7:0] cab_call,
    output logic [2:0] curr_floor,
    output logic [2:0] dest_floor,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic [7:0] pending
);
    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    localparam logic [7:0]  FLOOR_MASK  = 8'((1 << FLOORS) - 1);
    localparam logic [15:0] TRAVEL_LOAD = 16'(TRAVEL_CYCLES - 1);
    localparam logic [15:0] DOOR_LOAD   = 16'(DOOR_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] timer, timer_nx;
    logic [2:0]  floor_nx, step_floor;
    logic [7:0]  pending_nx, req_all, cur_onehot, step_onehot, above_mask, below_mask;
    logic        dir_nx, dir_sel, same_floor, has_above, has_below;

    // Out-of-range assignments shift into masked bits and vanish here.
    assign req_all     = (((assign_valid && assign_ready) ? (8'b1 << assign_floor) : 8'b0) | cab_call) & FLOOR_MASK;
    assign cur_onehot  = 8'b1 << curr_floor;
    assign same_floor  = |(req_all & cur_onehot);
    assign above_mask  = ~((cur_onehot << 1) - 8'd1);
    assign below_mask  = cur_onehot - 8'd1;
    assign has_above   = |(pending & above_mask);
    assign has_below   = |(pending & below_mask);
    assign dir_sel     = dir_up ? has_above : !has_below;
    assign step_floor  = dir_up ? curr_floor + 3'd1 : curr_floor - 3'd1;
    assign step_onehot = 8'b1 << step_floor;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            curr_floor   <= 3'd0;
            pending      <= 8'd0;
            dir_up       <= 1'b1;
            timer        <= 16'd0;
            assign_ready <= 1'b0;
            moving       <= 1'b0;
            door_open    <= 1'b0;
        end else begin
            state        <= state_nx;
            curr_floor   <= floor_nx;
            pending      <= pending_nx;
            dir_up       <= dir_nx;
            timer        <= timer_nx;
            assign_ready <= 1'b1;
            moving       <= (state_nx == MOVE);
            door_open    <= (state_nx == DOOR);
        end
    end

    always_comb begin
        state_nx   = state;
        floor_nx   = curr_floor;
        pending_nx = pending | req_all;
        dir_nx     = dir_up;
        timer_nx   = timer;
        case (state)
            IDLE: begin
                pending_nx = pending | (req_all & ~cur_onehot);
                if (same_floor) begin
                    state_nx = DOOR;
                    timer_nx = DOOR_LOAD;
                end else if (pending != 8'd0) begin
                    state_nx = MOVE;
                    dir_nx   = dir_sel;
                    timer_nx = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (timer == 16'd0) begin
                    floor_nx = step_floor;
                    // A call landing on the arrival floor in this same cycle still stops the car.
                    if (|((pending | req_all) & step_onehot)) begin
                        pending_nx = (pending | req_all) & ~step_onehot;
                        state_nx   = DOOR;
                        timer_nx   = DOOR_LOAD;
                    end else begin
                        timer_nx = TRAVEL_LOAD;
                    end
                end else begin
                    timer_nx = timer - 16'd1;
                end
            end
            DOOR: begin
                pending_nx = pending | (req_all & ~cur_onehot);
`ifdef LIFT_DOOR_REOPEN_EN
                if (same_floor) begin
                    timer_nx = DOOR_LOAD;
                end else
`endif
                if (timer == 16'd0) begin
                    if (pending != 8'd0) begin
                        state_nx = MOVE;
                        dir_nx   = dir_sel;
                        timer_nx = TRAVEL_LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx = timer - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Descending scan keeps the lowest hit going up; ascending keeps the highest going down.
    always_comb begin
        dest_floor = curr_floor;
        if (state == MOVE) begin
            if (dir_up) begin
                for (int i = FLOORS - 1; i >= 0; i--)
                    if (pending[i] && (3'(i) > curr_floor)) dest_floor = 3'(i);
            end else begin
                for (int i = 0; i < FLOORS; i++)
                    if (pending[i] && (3'(i) < curr_floor)) dest_floor = 3'(i);
            end
        end
    end
endmodule
